// File: rtl/divisor_segmentado_param.sv
// divisor_segmentado_param: pipelined signed/unsigned divider, one quotient bit per stage (DIV_ZERO_DET_EN adds DivZero).
// Latency: TAMANYO+2 active cycles from sampled Start to Done; accepts one operation per cycle.
// Backpressure: no ready; Hold=1 freezes every stage including the output registers.
module divisor_segmentado_param #(
  parameter int TAMANYO = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic               Hold,
  input  logic               Signo,
  input  logic [TAMANYO-1:0] Num,
  input  logic [TAMANYO-1:0] Den,
  output logic [TAMANYO-1:0] Q,
  output logic [TAMANYO-1:0] R,
`ifdef DIV_ZERO_DET_EN
  output logic               DivZero,
`endif
  output logic               Done
);

  localparam int T = TAMANYO;

  // Magnitudes of the operands; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  logic [T-1:0] num_abs;
  logic [T-1:0] den_abs;

  // Index 0 is the entry stage, index k the stage that resolved k quotient bits.
  logic [T-1:0] num_p [0:T-1];  // dividend magnitude, next bit to bring down at the MSB
  logic [T-1:0] den_p [0:T-1];
  logic [T-1:0] rem_p [0:T];
  logic [T-1:0] quo_p [0:T];
  logic         vld_p [0:T];
  logic         sq_p  [0:T];    // quotient must be negated
  logic         sr_p  [0:T];    // remainder must be negated
`ifdef DIV_ZERO_DET_EN
  logic         dz_p  [0:T];
  logic [T-1:0] norg_p [0:T];   // dividend exactly as supplied
`endif

  // Per-stage compare/subtract on the shifted partial remainder.
  logic [T:0]   trial [1:T];
  logic [T-1:0] diff  [1:T];
  logic         take  [1:T];

  // Operand magnitude at the entry.
  always_comb begin
    num_abs = (Signo && Num[T-1]) ? -Num : Num;
    den_abs = (Signo && Den[T-1]) ? -Den : Den;
  end

  // Restoring-division step for every iteration stage. The difference is kept
  // to T bits: when taken it is below |Den|, and with Den=0 it equals the trial.
  always_comb begin
    for (int k = 1; k <= T; k++) begin
      trial[k] = {rem_p[k-1], num_p[k-1][T-1]};
      diff[k]  = trial[k][T-1:0] - den_p[k-1];
      take[k]  = (trial[k] >= {1'b0, den_p[k-1]});
    end
  end

  // Pipeline registers: entry, iterations and output all advance together unless Hold.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int k = 0; k < T; k++) begin
        num_p[k] <= '0;
        den_p[k] <= '0;
      end
      for (int k = 0; k <= T; k++) begin
        rem_p[k] <= '0;
        quo_p[k] <= '0;
        vld_p[k] <= 1'b0;
        sq_p[k]  <= 1'b0;
        sr_p[k]  <= 1'b0;
`ifdef DIV_ZERO_DET_EN
        dz_p[k]   <= 1'b0;
        norg_p[k] <= '0;
`endif
      end
      Q    <= '0;
      R    <= '0;
      Done <= 1'b0;
`ifdef DIV_ZERO_DET_EN
      DivZero <= 1'b0;
`endif
    end else if (!Hold) begin
      // entry stage
      vld_p[0] <= Start;
      num_p[0] <= num_abs;
      den_p[0] <= den_abs;
      rem_p[0] <= '0;
      quo_p[0] <= '0;
      sq_p[0]  <= Signo & (Num[T-1] ^ Den[T-1]);
      sr_p[0]  <= Signo & Num[T-1];
`ifdef DIV_ZERO_DET_EN
      dz_p[0]   <= (Den == '0);
      norg_p[0] <= Num;
`endif
      // iteration stages: quotient bits shift in MSB first
      for (int k = 1; k <= T; k++) begin
        vld_p[k] <= vld_p[k-1];
        sq_p[k]  <= sq_p[k-1];
        sr_p[k]  <= sr_p[k-1];
        rem_p[k] <= take[k] ? diff[k] : trial[k][T-1:0];
        quo_p[k] <= {quo_p[k-1][T-2:0], take[k]};
`ifdef DIV_ZERO_DET_EN
        dz_p[k]   <= dz_p[k-1];
        norg_p[k] <= norg_p[k-1];
`endif
      end
      for (int k = 1; k < T; k++) begin
        num_p[k] <= {num_p[k-1][T-2:0], 1'b0};
        den_p[k] <= den_p[k-1];
      end
      // output stage: sign correction
      Done <= vld_p[T];
      Q    <= sq_p[T] ? -quo_p[T] : quo_p[T];
      R    <= sr_p[T] ? -rem_p[T] : rem_p[T];
`ifdef DIV_ZERO_DET_EN
      DivZero <= vld_p[T] & dz_p[T];
      if (dz_p[T]) begin
        Q <= '1;
        R <= norg_p[T];
      end
`endif
    end
  end

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// tb_divisor_segmentado_param: table-driven and scoreboard check of the pipelined divider at TAMANYO=8.
// Latency: expects Done 10 active cycles after the cycle Start is driven.
// Backpressure: exercises Hold stalls and mid-stream asynchronous reset.
module tb_divisor_segmentado_param;

  localparam int T = 8;

  logic         CLK = 1'b0;
  logic         RSTa = 1'b0;
  logic         Start = 1'b0;
  logic         Hold = 1'b0;
  logic         Signo = 1'b0;
  logic [T-1:0] Num = '0;
  logic [T-1:0] Den = '0;
  logic [T-1:0] Q;
  logic [T-1:0] R;
  logic         Done;
`ifdef DIV_ZERO_DET_EN
  logic         DivZero;
`endif

  divisor_segmentado_param #(.TAMANYO(T)) dut (
    .CLK     (CLK),
    .RSTa    (RSTa),
    .Start   (Start),
    .Hold    (Hold),
    .Signo   (Signo),
    .Num     (Num),
    .Den     (Den),
    .Q       (Q),
    .R       (R),
`ifdef DIV_ZERO_DET_EN
    .DivZero (DivZero),
`endif
    .Done    (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         s;
    logic [T-1:0] n;
    logic [T-1:0] d;
    logic [T-1:0] q;
    logic [T-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    int           id;
    logic [T-1:0] q;
    logic [T-1:0] r;
    logic         dz;
    int           act0;
    int           wall0;
    int           wall_exp;  // 0: wall-clock latency not checked
  } exp_t;

  exp_t  sb[$];
  exp_t  mx;
  vec_t  tbl [14];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    act_cnt = 0;
  int    wall_cnt = 0;
  int    done_cnt = 0;
  int    next_id = 0;
  logic  was_held;
  logic [31:0] prev_snap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] snap();
`ifdef DIV_ZERO_DET_EN
    return 32'({DivZero, Done, Q, R});
`else
    return 32'({Done, Q, R});
`endif
  endfunction

  // Reference divider: {dz, q, r}
  function automatic logic [2*T:0] ref_div(input logic s, input logic [T-1:0] n, input logic [T-1:0] d);
    int a, b, q, r;
    if (d == '0) begin
`ifdef DIV_ZERO_DET_EN
      return {1'b1, 8'hFF, n};
`else
      return {1'b0, (s && n[T-1]) ? 8'h01 : 8'hFF, n};
`endif
    end
    a = s ? int'($signed(n)) : int'(n);
    b = s ? int'($signed(d)) : int'(d);
    q = a / b;
    r = a % b;
    return {1'b0, q[T-1:0], r[T-1:0]};
  endfunction

  task automatic issue(input logic s, input logic [T-1:0] n, input logic [T-1:0] d,
                       input logic [2*T:0] e, input int wexp);
    exp_t x;
    Hold  = 1'b0;
    Start = 1'b1;
    Signo = s;
    Num   = n;
    Den   = d;
    x.id = next_id;
    next_id++;
    x.dz = e[2*T];
    x.q  = e[2*T-1:T];
    x.r  = e[T-1:0];
    x.act0 = act_cnt;
    x.wall0 = wall_cnt;
    x.wall_exp = wexp;
    sb.push_back(x);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic idle(input int n);
    Start = 1'b0;
    Hold  = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // Stall with Start asserted and junk operands: nothing may be accepted.
  task automatic stall(input int n);
    Hold  = 1'b1;
    Start = 1'b1;
    Num   = T'($urandom);
    Den   = T'($urandom);
    repeat (n) @(negedge CLK);
    Hold  = 1'b0;
    Start = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each new Done, checks freezing under Hold.
  always @(posedge CLK) begin
    was_held = Hold;
    wall_cnt++;
    if (!Hold) act_cnt++;
    #1;
    if (RSTa) begin
      if (was_held) begin
        check("hold_frozen", snap(), prev_snap);
      end else if (Done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_done: got Done=1 Q=0x%0h R=0x%0h, expected no result", Q, R);
        end else begin
          mx = sb.pop_front();
          check($sformatf("q#%0d", mx.id), 32'(Q), 32'(mx.q));
          check($sformatf("r#%0d", mx.id), 32'(R), 32'(mx.r));
`ifdef DIV_ZERO_DET_EN
          check($sformatf("dz#%0d", mx.id), 32'(DivZero), 32'(mx.dz));
`endif
          check($sformatf("lat_active#%0d", mx.id), 32'(act_cnt - mx.act0), 32'(T + 2));
          if (mx.wall_exp != 0)
            check($sformatf("lat_wall#%0d", mx.id), 32'(wall_cnt - mx.wall0), 32'(mx.wall_exp));
        end
      end
    end
    prev_snap = snap();
  end

  initial begin
    logic [2*T:0] e;
    int done_before;
    int bp_base;

    //          s     n      d      q      r      dz
    tbl[0]  = '{1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0};
    tbl[1]  = '{1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};
    tbl[2]  = '{1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0};
    tbl[3]  = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0};
    tbl[6]  = '{1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0};
    tbl[7]  = '{1'b1, 8'hF9, 8'hF9, 8'h01, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0};
`ifdef DIV_ZERO_DET_EN
    tbl[9]  = '{1'b1, 8'hB5, 8'h00, 8'hFF, 8'hB5, 1'b1};
`else
    tbl[9]  = '{1'b1, 8'hB5, 8'h00, 8'h01, 8'hB5, 1'b0};
`endif
    tbl[10] = '{1'b0, 8'h09, 8'h03, 8'h03, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 8'hFE, 8'h10, 8'h0F, 8'h0E, 1'b0};
    tbl[12] = '{1'b1, 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0};
    tbl[13] = '{1'b1, 8'h80, 8'h02, 8'hC0, 8'h00, 1'b0};

    // Reset state, asynchronous from time zero
    #1;
    check("reset_q", 32'(Q), 32'd0);
    check("reset_r", 32'(R), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
`ifdef DIV_ZERO_DET_EN
    check("reset_divzero", 32'(DivZero), 32'd0);
`endif
    repeat (3) @(negedge CLK);
    RSTa = 1'b1;
    idle(2);

    // Isolated 100/7: exact latency and single-cycle Done
    issue(1'b0, 8'd100, 8'd7, {1'b0, 8'h0E, 8'h02}, T + 2);
    idle(14);

    // Table, back to back
    for (int i = 0; i < 14; i++)
      issue(tbl[i].s, tbl[i].n, tbl[i].d, {tbl[i].dz, tbl[i].q, tbl[i].r}, T + 2);
    idle(14);

    // Eight consecutive starts Num=i*10+5, Den=3
    bp_base = done_cnt;
    for (int i = 0; i < 8; i++)
      issue(1'b0, T'(i * 10 + 5), 8'd3, {1'b0, T'((i * 10 + 5) / 3), T'((i * 10 + 5) % 3)}, T + 2);
    idle(14);
    check("burst_done_count", 32'(done_cnt - bp_base), 32'd8);

    // Four in flight, then a three-cycle stall
    for (int i = 0; i < 4; i++) begin
      e = ref_div(1'b1, T'(8'hE0 + i * 7), 8'hFD);
      issue(1'b1, T'(8'hE0 + i * 7), 8'hFD, e, T + 5);
    end
    stall(3);
    idle(14);

    // Reset with five in flight: everything discarded
    for (int i = 0; i < 5; i++)
      issue(1'b0, T'(50 + i), 8'd4, ref_div(1'b0, T'(50 + i), 8'd4), T + 2);
    idle(2);
    #3;
    RSTa = 1'b0;
    #1;
    check("midreset_q", 32'(Q), 32'd0);
    check("midreset_r", 32'(R), 32'd0);
    check("midreset_done", 32'(Done), 32'd0);
    sb.delete();
    @(negedge CLK);
    Hold = 1'b1;
    @(negedge CLK);
    RSTa = 1'b1;
    done_before = done_cnt;
    idle(15);
    check("no_done_after_reset", 32'(done_cnt), 32'(done_before));
    issue(1'b0, 8'd9, 8'd3, {1'b0, 8'h03, 8'h00}, T + 2);
    idle(14);

    // Random operands with bubbles and stalls
    for (int i = 0; i < 40; i++) begin
      logic         s;
      logic [T-1:0] n, d;
      s = 1'($urandom);
      n = T'($urandom);
      d = ($urandom_range(0, 7) == 0) ? '0 : T'($urandom);
      issue(s, n, d, ref_div(s, n, d), 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 5) == 0) stall($urandom_range(1, 2));
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
    check("drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divisor_segmentado_param.md
Name: divisor_segmentado_param

Overview:
Fully pipelined integer divider for a configurable word width, producing quotient and remainder. Each pipeline stage resolves one quotient bit by compare-and-subtract, so a new division can be accepted every clock cycle. It supports signed and unsigned operands, selected per operation, and a global stall. It is the drop-in datapath divider for the processing core and replaces the fixed-width single-step stage.

Parameters:
TAMANYO, 32, operand/result width in bits (>=4)

Ports:
CLK  input  1  clock, all registers rising-edge
RSTa  input  1  asynchronous active-low reset
Start  input  1  operation valid; operands sampled on rising CLK when Start=1 and Hold=0
Hold  input  1  stall; while 1 every pipeline register (data and valid) keeps its value
Signo  input  1  1=signed two's-complement operation, 0=unsigned; sampled with Start
Num  input  TAMANYO  dividend
Den  input  TAMANYO  divisor
Q  output  TAMANYO  quotient
R  output  TAMANYO  remainder
Done  output  1  Q/R valid, one-cycle pulse per operation (held while Hold=1)
DivZero  output  1  only with DIV_ZERO_DET_EN; divisor was zero, aligned with Done

Behaviour:
- Reset: the clock is CLK. The reset is RSTa: asynchronous and active-low. Asserting RSTa clears every pipeline register immediately, including valid bits. Q=0, R=0, Done=0, DivZero=0. Any in-flight operations are discarded and never produce Done.
- Pipeline: TAMANYO+2 register stages.
  - Stage E (entry): registers |Num|, |Den|, Signo, sign of quotient (Num_msb XOR Den_msb, signed only), sign of remainder (Num_msb, signed only), and the valid bit (=Start).
  - Stages 1..TAMANYO (iteration): stage k shifts the partial remainder left by one and brings in dividend bit TAMANYO-k. It compares the result against |Den| using a TAMANYO+1 bit unsigned compare/subtract. If the value is >= |Den|, it subtracts and sets quotient bit TAMANYO-k to 1; otherwise it keeps the value and sets the bit to 0. Operands and flags travel alongside.
  - Stage S (output): applies two's-complement negation to the quotient and/or remainder when the corresponding sign flag is set. It registers Q, R and Done.
- Latency: Done asserts exactly TAMANYO+2 active (non-Hold) cycles after the cycle Start was sampled.
- Throughput: one operation per cycle, no bubbles inserted; results leave in issue order.
- Start=0 inserts a bubble. Data registers of invalid stages may hold any value, but Done must be 0 for them.
- Hold: freezes the whole pipeline, including the output stage. Done/Q/R stay stable while Hold=1, and Start is ignored.
  - Hold together with RSTa low: reset wins.
- Absolute value: |x| for signed is computed in TAMANYO bits. The most negative value stays 2^(TAMANYO-1) interpreted as unsigned, which is correct for the magnitude datapath.
- Signed semantics: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - Overflow case MIN/-1 gives Q=MIN, R=0 (natural wrap), with no flag.
- Unsigned: Signo=0 ignores the MSB as a sign, and both sign flags are 0.
- Divisor zero without the feature: the raw algorithm result is delivered. Every compare succeeds, so the magnitude quotient is all ones and the magnitude remainder is |Num|. The sign correction is then applied as normal, and the result carries no special meaning.

Optional Feature:
DIV_ZERO_DET_EN:
- Defined:
  - Stage E computes Den==0 and pipelines it as a flag.
  - Port DivZero exists and equals that flag when Done=1 (0 otherwise).
  - Stage S then forces Q = all ones and R = Num as originally supplied (the original signed/unsigned Num carried down the pipe), regardless of Signo.
- Undefined: the DivZero port and flag registers are absent, and the divisor-zero result follows the raw algorithm as in Behaviour.

Test Plan:
- TAMANYO=8, unsigned 100/7, Start one cycle -> Done exactly 10 cycles later with Q=14 (0x0E), R=2; Done high one cycle only.
- TAMANYO=8, signed -100/7 (0x9C/0x07) -> Q=0xF2 (-14), R=0xFE (-2). Also 100/-7 -> Q=0xF2, R=0x02. And -128/-1 -> Q=0x80, R=0x00.
- Back-to-back: 8 consecutive Start cycles with Num=i*10+5, Den=3 for i=0..7 -> Done high 8 consecutive cycles, with results in order (Q=1,5,8,11,15,18,21,25).
- Hold asserted 3 cycles while 4 operations are in flight -> Done/Q/R frozen during Hold, and no operation is lost or duplicated. Total latency of each is 10 + 3.
- RSTa pulsed low mid-stream with 5 operations in flight -> outputs 0 immediately, and no Done after release until a new Start + 10 cycles.
- With DIV_ZERO_DET_EN defined, signed 0xB5/0 -> Done with DivZero=1, Q=0xFF, R=0xB5. A following 9/3 has DivZero=0, Q=3, R=0.
